// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32x32 multiply / 32/32 divide unit.
// An operation takes one operand-latch edge, 32 RUN steps and one FIX step.
// The result lands in Hi/Lo together with a one-cycle Done pulse.
// Ports:
//   Clk, Reset (sync, active-low)
//   Start, OpDiv, OpUnsigned, Op1, Op2 : request, sampled only in IDLE
//   ReadHi, ReadLo                     : pipeline read attempts, used for Stall
//   Busy, Done, DivByZero              : status
//   Hi, Lo                             : result registers
//   Stall                              : combinational pipeline hold request
module muldiv_seq (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        OpDiv,
    input  logic        OpUnsigned,
    input  logic [31:0] Op1,
    input  logic [31:0] Op2,
    input  logic        ReadHi,
    input  logic        ReadLo,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        DivByZero,
    output logic        Stall
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic        div_q, negq_q, negr_q, dbz_q;
    logic [31:0] op1_q;          // raw dividend, returned as Hi on divide-by-zero
    logic [31:0] opb_q;          // multiplicand (mult) or divisor (div) magnitude
    logic [31:0] acc_hi_q;       // product high half / partial remainder
    logic [31:0] acc_lo_q;       // multiplier bits / dividend-quotient shift reg
    logic [31:0] hi_q, lo_q;
    logic        done_q, dbzo_q;

    // Operand magnitudes and signs at Start
    logic        s1, s2;
    logic [31:0] a_mag, b_mag;
    always_comb begin
        s1    = ~OpUnsigned & Op1[31];
        s2    = ~OpUnsigned & Op2[31];
        a_mag = s1 ? -Op1 : Op1;
        b_mag = s2 ? -Op2 : Op2;
    end

    // One iteration step
    logic [32:0] sum, rsh, diff;
    logic [31:0] acc_hi_d, acc_lo_d;
    always_comb begin
        sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);
        rsh  = {acc_hi_q, acc_lo_q[31]};
        diff = rsh - {1'b0, opb_q};
        if (!div_q) begin
            // shift-add: carry and sum shift right into the product
            acc_hi_d = sum[32:1];
            acc_lo_d = {sum[0], acc_lo_q[31:1]};
        end else if (!diff[32]) begin
            // restoring divide: subtraction fits, keep it and shift in a 1
            acc_hi_d = diff[31:0];
            acc_lo_d = {acc_lo_q[30:0], 1'b1};
        end else begin
            acc_hi_d = rsh[31:0];
            acc_lo_d = {acc_lo_q[30:0], 1'b0};
        end
    end

    // Sign correction applied in FIX
    logic [63:0] prod;
    logic [31:0] fix_hi, fix_lo;
    always_comb begin
        prod = {acc_hi_q, acc_lo_q};
        if (negq_q) prod = -prod;
        if (!div_q) begin
            fix_hi = prod[63:32];
            fix_lo = prod[31:0];
        end else if (dbz_q) begin
            fix_hi = op1_q;
            fix_lo = 32'hFFFF_FFFF;
        end else begin
            fix_hi = negr_q ? -acc_hi_q : acc_hi_q;
            fix_lo = negq_q ? -acc_lo_q : acc_lo_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            dbz_q    <= 1'b0;
            op1_q    <= '0;
            opb_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbzo_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbzo_q <= 1'b0;
            case (state_q)
                IDLE: if (Start) begin
                    div_q    <= OpDiv;
                    negq_q   <= s1 ^ s2;
                    negr_q   <= s1;
                    dbz_q    <= OpDiv & (Op2 == 32'd0);
                    op1_q    <= Op1;
                    opb_q    <= OpDiv ? b_mag : a_mag;
                    acc_hi_q <= '0;
                    acc_lo_q <= OpDiv ? a_mag : b_mag;
                    cnt_q    <= '0;
                    state_q  <= RUN;
                end
                RUN: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    dbzo_q  <= dbz_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy      = (state_q != IDLE);
    assign Done      = done_q;
    assign DivByZero = dbzo_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign Stall     = Busy & (ReadHi | ReadLo | Start);

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0, OpDiv = 1'b0, OpUnsigned = 1'b0;
    logic [31:0] Op1 = '0, Op2 = '0;
    logic        ReadHi = 1'b0, ReadLo = 1'b0;
    logic        Busy, Done, DivByZero, Stall;
    logic [31:0] Hi, Lo;

    int errors = 0;
    int checks = 0;

    muldiv_seq dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .OpDiv(OpDiv),
        .OpUnsigned(OpUnsigned), .Op1(Op1), .Op2(Op2),
        .ReadHi(ReadHi), .ReadLo(ReadLo), .Busy(Busy), .Done(Done),
        .Hi(Hi), .Lo(Lo), .DivByZero(DivByZero), .Stall(Stall)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        d, u;
        logic [31:0] a, b, hi, lo;
        logic        z;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Issue one operation and wait for Done (bounded). imm=1 drives Start
    // right away (used in the Done cycle), otherwise at the next negedge.
    task automatic run_op(input bit imm, input logic d, u, input logic [31:0] a, b,
                          output int lat, output int bc,
                          output logic [31:0] h, l, output logic z);
        if (!imm) @(negedge Clk);
        OpDiv = d; OpUnsigned = u; Op1 = a; Op2 = b; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0; Op1 = $urandom; Op2 = $urandom;
        bc = Busy ? 1 : 0;
        lat = 0;
        while (lat < 60) begin
            @(posedge Clk); #1;
            lat++;
            if (Done) break;
            bc += Busy ? 1 : 0;
        end
        h = Hi; l = Lo; z = DivByZero;
    endtask

    int          lat, bc, ndone;
    logic [31:0] h, l;
    logic        z;

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 32'd1000,     32'd7,        32'd6,        32'd142,      1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};

        // reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk); Reset = 1'b1; ReadHi = 1'b1;
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_dbz", DivByZero, 0);
        chk("rst_hi", Hi, 0);
        chk("rst_lo", Lo, 0);
        chk("rst_stall", Stall, 0);
        ReadHi = 1'b0;

        // table-driven operations
        for (int i = 0; i < 12; i++) begin
            run_op(1'b0, tbl[i].d, tbl[i].u, tbl[i].a, tbl[i].b, lat, bc, h, l, z);
            chk($sformatf("v%0d_lat", i), lat, 33);
            chk($sformatf("v%0d_busy", i), bc, 33);
            chk($sformatf("v%0d_hi", i), h, tbl[i].hi);
            chk($sformatf("v%0d_lo", i), l, tbl[i].lo);
            chk($sformatf("v%0d_dbz", i), z, tbl[i].z);
            @(posedge Clk); #1;
            chk($sformatf("v%0d_done_pulse", i), {Done, DivByZero}, 2'b00);
            chk($sformatf("v%0d_hold", i), {Hi, Lo}, {tbl[i].hi, tbl[i].lo});
        end

        // Start during RUN is ignored; Stall tracks Start/ReadLo while busy
        @(negedge Clk);
        OpDiv = 1'b0; OpUnsigned = 1'b1; Op1 = 32'd6; Op2 = 32'd7; Start = 1'b1;
        @(posedge Clk); #1; Start = 1'b0;
        lat = 0;
        repeat (4) begin @(posedge Clk); lat++; end
        @(negedge Clk);
        Start = 1'b1; OpDiv = 1'b1; Op1 = 32'd100; Op2 = 32'd3;
        #1 chk("stall_start", Stall, 1);
        @(posedge Clk); lat++; #1; Start = 1'b0;
        ReadLo = 1'b1;
        #1 chk("stall_readlo_busy", Stall, 1);
        ReadLo = 1'b0;
        while (lat < 60) begin
            @(posedge Clk); #1; lat++;
            if (Done) break;
        end
        chk("ign_lat", lat, 33);
        chk("ign_result", {Hi, Lo}, 64'd42);
        ndone = 0;
        repeat (40) begin @(posedge Clk); #1; if (Done) ndone++; end
        chk("ign_not_queued", ndone, 0);
        ReadLo = 1'b1;
        #1 chk("stall_readlo_idle", Stall, 0);
        ReadLo = 1'b0;

        // back-to-back: second Start issued in the Done cycle
        run_op(1'b0, 1'b0, 1'b1, 32'd5, 32'd5, lat, bc, h, l, z);
        chk("b2b_first", {h, l}, 64'd25);
        run_op(1'b1, 1'b1, 1'b1, 32'd100, 32'd7, lat, bc, h, l, z);
        chk("b2b_lat", lat, 33);
        chk("b2b_hi", h, 32'd2);
        chk("b2b_lo", l, 32'd14);

        // reset during RUN iteration 10 aborts without Done
        @(negedge Clk);
        OpDiv = 1'b0; OpUnsigned = 1'b1; Op1 = 32'd9; Op2 = 32'd9; Start = 1'b1;
        @(posedge Clk); #1; Start = 1'b0;
        repeat (10) @(posedge Clk);
        @(negedge Clk); Reset = 1'b0;
        @(posedge Clk); #1;
        chk("abort_busy", Busy, 0);
        chk("abort_hilo", {Hi, Lo}, 64'd0);
        @(negedge Clk); Reset = 1'b1;
        ndone = 0;
        repeat (40) begin @(posedge Clk); #1; if (Done) ndone++; end
        chk("abort_no_done", ndone, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 No parameters; the operand width is fixed at 32 bits and the iteration count is fixed at 32.
REQ-002 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Reset  input  1  synchronous, active-low; Reset==0 at a rising edge resets the block.
REQ-004 Start  input  1  request a new operation; sampled only in IDLE.
REQ-005 OpDiv  input  1  0=multiply, 1=divide; sampled with Start.
REQ-006 OpUnsigned  input  1  1=unsigned, 0=two's-complement signed; sampled with Start.
REQ-007 Op1  input  32  multiplicand/dividend; sampled with Start.
REQ-008 Op2  input  32  multiplier/divisor; sampled with Start.
REQ-009 ReadHi, ReadLo  input  1 each  the pipeline is attempting to read Hi/Lo this cycle.
REQ-010 Busy  output  1  high while an operation is in progress.
REQ-011 Done  output  1  one-cycle pulse; Hi/Lo hold the new result in that cycle.
REQ-012 Hi, Lo  output  32 each  result registers.
REQ-013 DivByZero  output  1  pulses with Done when a divide had Op2==0.
REQ-014 Stall  output  1  combinational pipeline hold request.

Function
REQ-015 FSM states: IDLE, RUN, FIX; Busy SHALL equal (state != IDLE).
REQ-016 In IDLE, Start==1 at an edge SHALL latch the operands, OpDiv and OpUnsigned, convert signed operands to magnitudes, record the result signs, clear the iteration counter, and enter RUN.
REQ-017 RUN SHALL perform exactly one shift-add (mult) or restoring shift-subtract (div) step per cycle for 32 cycles; the 5-bit counter wraps 31->0 and moves the FSM to FIX.
REQ-018 FIX SHALL apply sign correction, write Hi/Lo, assert Done and DivByZero (if applicable) registered for the following cycle, and return to IDLE.
REQ-019 Latency: Start sampled at edge k -> Done==1 and Busy==0 in the cycle after edge k+33; Hi/Lo are valid from that cycle on.
REQ-020 Multiply: {Hi,Lo} SHALL equal the 64-bit product; in signed mode the product is negated when the operand signs differ.
REQ-021 Divide: Lo SHALL equal the quotient and Hi the remainder; in signed mode the quotient is negated when the signs differ and the remainder takes the dividend's sign.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give Lo=0x80000000 and Hi=0 without any exception output.
REQ-023 A divide with Op2==0 SHALL still take 33 cycles, give Lo=0xFFFFFFFF and Hi=Op1 (raw, with no sign fix), and pulse DivByZero with Done.
REQ-024 Start while Busy SHALL be ignored and not queued; Start in the Done cycle (state IDLE) SHALL be accepted.
REQ-025 Stall SHALL equal Busy & (ReadHi | ReadLo | Start).
REQ-026 Hi/Lo SHALL hold their value except in FIX and reset; operand inputs are don't-care outside the Start cycle.
REQ-027 Done and DivByZero SHALL be high for exactly one cycle per completed operation.

Reset
REQ-028 On Reset==0 at an edge: state=IDLE, Busy=0, Done=0, DivByZero=0, Hi=0, Lo=0, and the counter and working registers are cleared.
REQ-029 Reset mid-operation (RUN or FIX) SHALL abort the operation with no Done pulse; reset has priority over Start.

Verification
REQ-030 Unsigned mult 0xFFFFFFFF*0xFFFFFFFF -> Done 33 cycles after the Start edge, Hi=0xFFFFFFFE, Lo=0x00000001, Busy high for exactly 33 cycles.
REQ-031 Signed mult -3*7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; signed div -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
REQ-032 Unsigned div 100/0 -> Lo=0xFFFFFFFF, Hi=0x00000064, DivByZero=1 with Done; signed 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
REQ-033 Start at cycle 5 of RUN with new operands -> ignored, Stall=1 that cycle, first result unchanged; ReadLo while Busy -> Stall=1; ReadLo while IDLE -> Stall=0.
REQ-034 Back-to-back: Start asserted in the Done cycle -> accepted, second Done exactly 33 cycles later.
REQ-035 Reset=0 during RUN iteration 10 -> the next cycle shows Busy=0, Hi=Lo=0, and no Done pulse thereafter.
